// File: rtl/dmem_mmio_bridge_if.sv
// Processor data-port bus plus the RAM and TX-byte side channels of the MMIO bridge.
// TX handshake: a byte moves when tx_valid & tx_ready at a rising edge; tx_data holds while tx_valid & !tx_ready.
interface dmem_mmio_bridge_if #(
    parameter int RAM_AW = 12
);
    logic [31:0]       address_dmem;
    logic [31:0]       data;
    logic              wren;
    logic [31:0]       q_dmem;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic [31:0]       ram_q;
    logic [7:0]        led;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport slave (
        input  address_dmem, data, wren, ram_q, tx_ready,
        output q_dmem, ram_addr, ram_data, ram_wren, led, tx_data, tx_valid
    );

    modport master (
        output address_dmem, data, wren, ram_q, tx_ready,
        input  q_dmem, ram_addr, ram_data, ram_wren, led, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Data-memory bridge: routes processor loads/stores to an external synchronous RAM or to
// LED, 64-bit cycle counter and TX byte FIFO registers, with one-cycle read latency everywhere.
module dmem_mmio_bridge #(
    parameter int RAM_AW     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    dmem_mmio_bridge_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [31:0] LED_ADDR    = 32'h0000_1000;
    localparam logic [31:0] CYC_LO_ADDR = 32'h0000_1001;
    localparam logic [31:0] CYC_HI_ADDR = 32'h0000_1002;
    localparam logic [31:0] TX_DATA_ADDR = 32'h0000_1003;
    localparam logic [31:0] TX_STAT_ADDR = 32'h0000_1004;

    logic [7:0]    led_r;
    logic [63:0]   cycle_cnt;
    logic [31:0]   hi_snap;
    logic          overflow;
    logic          sel_ram;
    logic [31:0]   mmio_q;
    logic [31:0]   rd_val;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_cnt;

    logic ram_hit;
    logic is_load;
    logic fifo_full;
    logic fifo_empty;
    logic push_req;
    logic push;
    logic pop;
    logic overflow_evt;
    logic [2:0] cnt3;

    assign ram_hit      = (bus.address_dmem[31:RAM_AW] == '0);
    assign is_load      = !bus.wren;
    assign fifo_full    = (fifo_cnt == FULL_CNT);
    assign fifo_empty   = (fifo_cnt == '0);
    assign push_req     = bus.wren && (bus.address_dmem == TX_DATA_ADDR);
    assign pop          = !fifo_empty && bus.tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_evt = push_req && fifo_full && !pop;
    assign cnt3         = 3'(fifo_cnt);

    assign bus.ram_addr = bus.address_dmem[RAM_AW-1:0];
    assign bus.ram_data = bus.data;
    assign bus.ram_wren = bus.wren && ram_hit;
    assign bus.q_dmem   = sel_ram ? bus.ram_q : mmio_q;
    assign bus.led      = led_r;
    assign bus.tx_data  = fifo_mem[rd_ptr];
    assign bus.tx_valid = !fifo_empty;

    always_comb begin
        rd_val = '0;
        case (bus.address_dmem)
            LED_ADDR:     rd_val = {24'b0, led_r};
            CYC_LO_ADDR:  rd_val = cycle_cnt[31:0];
            CYC_HI_ADDR:  rd_val = hi_snap;
            TX_STAT_ADDR: rd_val = {26'b0, overflow, cnt3, fifo_empty, fifo_full};
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            led_r     <= '0;
            cycle_cnt <= '0;
            hi_snap   <= '0;
            overflow  <= 1'b0;
            sel_ram   <= 1'b0;
            mmio_q    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            sel_ram   <= ram_hit;
            mmio_q    <= rd_val;
            if (bus.wren && (bus.address_dmem == LED_ADDR)) begin
                led_r <= bus.data[7:0];
            end
            // HI reads return this snapshot so a LO-then-HI pair is coherent.
            if (is_load && (bus.address_dmem == CYC_LO_ADDR)) begin
                hi_snap <= cycle_cnt[63:32];
            end
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (is_load && (bus.address_dmem == TX_STAT_ADDR)) begin
                overflow <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= bus.data[7:0];
        end
    end
endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Self-checking bench for dmem_mmio_bridge: reference model of all registers, RAM and TX FIFO,
// with load results and popped TX bytes compared against scoreboard queues.
module tb_dmem_mmio_bridge;
    logic clock;
    logic reset;

    dmem_mmio_bridge_if #(.RAM_AW(12)) bus ();

    dmem_mmio_bridge #(
        .RAM_AW(12),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // external synchronous RAM
    logic [31:0] ram_mem [4096];
    always @(posedge clock) begin
        if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= ram_mem[bus.ram_addr];
    end

    int total = 0;
    int bad = 0;

    // scoreboard state
    logic [31:0] exp_q[$];
    logic        chk_q[$];
    logic [7:0]  tx_m[$];
    logic        ovf_m;
    logic [63:0] cnt_m;
    logic [31:0] snap_m;
    logic [7:0]  led_m;
    logic [31:0] ref_ram [4096];
    logic        ref_v [4096];
    logic        model_ok = 1'b0;
    logic        rst_v;
    logic        force_req = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: check previous load, drive new inputs, check live outputs, advance model.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        logic        c;
        logic [31:0] e;
        logic        pop_m;
        logic        full_b;
        logic [31:0] stat;
        @(negedge clock);
        if (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            e = exp_q.pop_front();
            if (c) check_eq("q_dmem", bus.q_dmem, e);
        end
        reset = rst_v;
        bus.address_dmem = a;
        bus.data = d;
        bus.wren = we;
        bus.tx_ready = rdy;
        if (force_req) begin
            force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
            release dut.cycle_cnt;
            cnt_m = 64'h0000_0000_FFFF_FFFF;
            force_req = 1'b0;
        end
        #1;
        check_eq("ram_wren", {31'b0, bus.ram_wren}, {31'b0, we && (a[31:12] == 20'h0)});
        if (model_ok) begin
            check_eq("tx_valid", {31'b0, bus.tx_valid}, {31'b0, tx_m.size() != 0});
            check_eq("led", {24'b0, bus.led}, {24'b0, led_m});
        end
        if (!rst_v) begin
            tx_m.delete();
            ovf_m = 1'b0;
            cnt_m = '0;
            snap_m = '0;
            led_m = '0;
            model_ok = 1'b1;
            exp_q.push_back(32'h0);
            chk_q.push_back(1'b1);
            return;
        end
        full_b = (tx_m.size() == 4);
        pop_m = (tx_m.size() != 0) && rdy;
        if (pop_m) check_eq("tx_data", {24'b0, bus.tx_data}, {24'b0, tx_m[0]});
        stat = {26'b0, ovf_m, 3'(tx_m.size()), tx_m.size() == 0, full_b};
        c = 1'b0;
        e = '0;
        if (!we) begin
            c = 1'b1;
            if (a[31:12] == 20'h0) begin
                c = ref_v[a[11:0]];
                e = ref_ram[a[11:0]];
            end else begin
                case (a)
                    32'h1000: e = {24'b0, led_m};
                    32'h1001: e = cnt_m[31:0];
                    32'h1002: e = snap_m;
                    32'h1004: e = stat;
                    default:  e = 32'h0;
                endcase
            end
        end
        exp_q.push_back(e);
        chk_q.push_back(c);
        if (pop_m) void'(tx_m.pop_front());
        if (we) begin
            if (a[31:12] == 20'h0) begin
                ref_ram[a[11:0]] = d;
                ref_v[a[11:0]] = 1'b1;
            end else if (a == 32'h1000) begin
                led_m = d[7:0];
            end else if (a == 32'h1003) begin
                if (!full_b || pop_m) tx_m.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end
        end else begin
            if (a == 32'h1001) snap_m = cnt_m[63:32];
            if (a == 32'h1004) ovf_m = 1'b0;
        end
        cnt_m = cnt_m + 64'd1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(32'hFFFF, 32'h0, 1'b0, rdy);
    endtask

    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 4096; i++) ref_v[i] = 1'b0;
        rst_v = 1'b0;
        reset = 1'b0;
        bus.address_dmem = 32'hFFFF;
        bus.data = '0;
        bus.wren = 1'b0;
        bus.tx_ready = 1'b0;
        idle(2, 1'b0);
        rst_v = 1'b1;

        // counter: 10 cycles after reset release, then LO/HI snapshot across a LO-word wrap
        idle(10, 1'b0);
        cyc(32'h1001, 32'h0, 1'b0, 1'b0);
        cyc(32'h1002, 32'h0, 1'b0, 1'b0);
        force_req = 1'b1;
        cyc(32'h1001, 32'h0, 1'b0, 1'b0);
        cyc(32'h1002, 32'h0, 1'b0, 1'b0);
        cyc(32'h1001, 32'h0, 1'b0, 1'b0);
        cyc(32'h1002, 32'h0, 1'b0, 1'b0);
        cyc(32'h1001, 32'h1234, 1'b1, 1'b0);
        cyc(32'h1002, 32'h5678, 1'b1, 1'b0);
        cyc(32'h1002, 32'h0, 1'b0, 1'b0);

        // RAM
        cyc(32'h5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc(32'h5, 32'h0, 1'b0, 1'b0);
        cyc(32'h8000_0005, 32'h0BAD_0BAD, 1'b1, 1'b0);
        cyc(32'h0000_1005, 32'h0BAD_0BAD, 1'b1, 1'b0);
        cyc(32'h5, 32'h0, 1'b0, 1'b0);
        cyc(32'hFFF, 32'hCAFE_F00D, 1'b1, 1'b0);
        cyc(32'hFFF, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ra = $urandom_range(16, 63);
            cyc(ra, $urandom, 1'b1, 1'b0);
            cyc(ra, 32'h0, 1'b0, 1'b0);
        end

        // LED
        cyc(32'h1000, 32'h1A5, 1'b1, 1'b0);
        cyc(32'h1000, 32'h0, 1'b0, 1'b0);
        cyc(32'h1006, 32'h77, 1'b1, 1'b0);
        cyc(32'h1006, 32'h0, 1'b0, 1'b0);

        // FIFO overflow then drain
        for (int i = 1; i <= 5; i++) cyc(32'h1003, 32'(i * 8'h11), 1'b1, 1'b0);
        cyc(32'h1004, 32'h0, 1'b0, 1'b0);
        cyc(32'h1003, 32'h0, 1'b0, 1'b0);
        idle(5, 1'b1);
        cyc(32'h1004, 32'h0, 1'b0, 1'b0);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(32'h1003, 32'hA0 + 32'(i), 1'b1, 1'b0);
        cyc(32'h1003, 32'hA4, 1'b1, 1'b1);
        cyc(32'h1004, 32'h0, 1'b0, 1'b0);
        idle(5, 1'b1);
        cyc(32'h1004, 32'h0, 1'b0, 1'b0);

        // random FIFO traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: cyc(32'h1003, $urandom, 1'b1, 1'($urandom_range(0, 1)));
                2:    cyc(32'h1004, 32'h0, 1'b0, 1'($urandom_range(0, 1)));
                default: idle(1, 1'($urandom_range(0, 1)));
            endcase
        end
        idle(6, 1'b1);

        // reset with bytes queued
        for (int i = 0; i < 3; i++) cyc(32'h1003, 32'h60 + 32'(i), 1'b1, 1'b0);
        rst_v = 1'b0;
        idle(1, 1'b0);
        rst_v = 1'b1;
        cyc(32'h1004, 32'h0, 1'b0, 1'b1);
        cyc(32'hFFFF, 32'h0, 1'b0, 1'b1);
        cyc(32'h1000, 32'h0, 1'b0, 1'b0);
        idle(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
